// File: rtl/pool_pkg.sv
// Shared types for the 2x2/stride-2 max-pool sequencer: FSM states, window phases and default widths.
// Fused ReLU is selected in pool_max4 by the POOL_RELU_EN macro.
package pool_pkg;
  localparam int DEF_DW  = 8;
  localparam int DEF_IAW = 25;
  localparam int DEF_OAW = 16;

  typedef enum logic [2:0] {IDLE, SETUP, READ, DRAIN, DONE} state_t;
  typedef enum logic [1:0] {PH_TL, PH_TR, PH_BL, PH_BR} phase_t;
endpackage

// File: rtl/pool_max4.sv
// Running signed max over one 2x2 window; ReLU on the result when POOL_RELU_EN is defined.
// Result registered 1 cycle after the 4th element; no backpressure, accepts one element per cycle.
module pool_max4
  import pool_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  phase_t               phase,
  input  logic                 data_valid,
  input  logic signed [DW-1:0] data,
  output logic signed [DW-1:0] result,
  output logic                 result_valid
);

  logic signed [DW-1:0] acc;
  logic signed [DW-1:0] acc_max;
  logic signed [DW-1:0] pooled;

  always_comb begin
    acc_max = (data > acc) ? data : acc;
`ifdef POOL_RELU_EN
    pooled = acc_max[DW-1] ? '0 : acc_max;
`else
    pooled = acc_max;
`endif
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= data_valid && (phase == PH_BR);
      if (data_valid) begin
        acc <= (phase == PH_TL) ? data : acc_max;
        if (phase == PH_BR) result <= pooled;
      end
    end
  end

endmodule

// File: rtl/pool_ctrl.sv
// Max-pool sequencer: walks the input map, one read per cycle, one pooled write per window (POOL_RELU_EN in pool_max4).
// First write 6 cycles after start detection; no backpressure, buffers must accept every strobe.
module pool_ctrl
  import pool_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int IAW = DEF_IAW,
  parameter int OAW = DEF_OAW
) (
  input  logic           PCLK,
  input  logic           PRESET,
  input  logic           pool_start,
  input  logic [7:0]     width,
  input  logic [7:0]     height,
  input  logic [8:0]     length,
  input  logic [OAW-1:0] out_base,
  output logic           pool_done,
  output logic [31:0]    clk_counter,
  output logic           in_rd_en,
  output logic [IAW-1:0] in_rd_addr,
  input  logic [DW-1:0]  in_rd_data,
  output logic           out_wr_en,
  output logic [OAW-1:0] out_wr_addr,
  output logic [DW-1:0]  out_wr_data
);

  state_t         state, state_nxt;
  logic           start_q;
  logic [IAW-1:0] w_r, wh_r, win_base, row_base, chan_base, rd_addr_nxt;
  logic [15:0]    wh_prod;
  logic [6:0]     wo_r, ho_r, x_cnt, y_cnt;
  logic [8:0]     c_r, c_cnt;
  phase_t         phase, rd_phase, dv_phase;
  logic           dv_q, degenerate, issue, last_x, last_y, last_c, last_rd;
  logic [OAW-1:0] wr_ptr;
  logic           res_vld;
  logic [DW-1:0]  res_dat;

  assign wh_prod    = 16'(width) * 16'(height);
  assign degenerate = (width[7:1] == 7'd0) || (height[7:1] == 7'd0) || (length == 9'd0);
  assign issue      = ((state == SETUP) && !degenerate) || (state == READ);
  assign last_x     = (x_cnt == wo_r - 7'd1);
  assign last_y     = (y_cnt == ho_r - 7'd1);
  assign last_c     = (c_cnt == c_r - 9'd1);
  assign last_rd    = (phase == PH_BR) && last_x && last_y && last_c;

  always_comb begin
    rd_addr_nxt = win_base;
    if (phase == PH_BL || phase == PH_BR) rd_addr_nxt = rd_addr_nxt + w_r;
    if (phase == PH_TR || phase == PH_BR) rd_addr_nxt = rd_addr_nxt + IAW'(1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pool_start && !start_q) state_nxt = SETUP;
      SETUP:   state_nxt = degenerate ? DONE : READ;
      READ:    if (last_rd) state_nxt = DRAIN;
      DRAIN:   if (out_wr_en) state_nxt = DONE;
      DONE:    if (!pool_start && pool_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      pool_done   <= 1'b0;
      clk_counter <= '0;
      w_r         <= '0;
      wh_r        <= '0;
      wo_r        <= '0;
      ho_r        <= '0;
      c_r         <= '0;
      win_base    <= '0;
      row_base    <= '0;
      chan_base   <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      c_cnt       <= '0;
      phase       <= PH_TL;
      rd_phase    <= PH_TL;
      dv_phase    <= PH_TL;
      dv_q        <= 1'b0;
      in_rd_en    <= 1'b0;
      in_rd_addr  <= '0;
      wr_ptr      <= '0;
    end else begin
      state    <= state_nxt;
      start_q  <= pool_start;
      // Degenerate jobs sit in DONE one cycle before the flag rises.
      pool_done <= (state_nxt == DONE) && (state == DRAIN || state == DONE);
      dv_q     <= in_rd_en;
      dv_phase <= rd_phase;
      in_rd_en <= issue;

      if (state == SETUP) begin
        clk_counter <= 32'd1;
        w_r         <= IAW'(width);
        wh_r        <= IAW'(wh_prod);
        wo_r        <= width[7:1];
        ho_r        <= height[7:1];
        c_r         <= length;
        wr_ptr      <= out_base;
      end else if (state == READ || state == DRAIN) begin
        clk_counter <= clk_counter + 32'd1;
      end

      if (state == IDLE) begin
        win_base  <= '0;
        row_base  <= '0;
        chan_base <= '0;
        x_cnt     <= '0;
        y_cnt     <= '0;
        c_cnt     <= '0;
        phase     <= PH_TL;
      end

      if (issue) begin
        in_rd_addr <= rd_addr_nxt;
        rd_phase   <= phase;
        phase      <= phase_t'(phase + 2'd1);
        if (phase == PH_BR) begin
          if (!last_x) begin
            x_cnt    <= x_cnt + 7'd1;
            win_base <= win_base + IAW'(2);
          end else if (!last_y) begin
            x_cnt    <= '0;
            y_cnt    <= y_cnt + 7'd1;
            row_base <= row_base + (w_r << 1);
            win_base <= row_base + (w_r << 1);
          end else begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            c_cnt     <= c_cnt + 9'd1;
            chan_base <= chan_base + wh_r;
            row_base  <= chan_base + wh_r;
            win_base  <= chan_base + wh_r;
          end
        end
      end

      if (out_wr_en) wr_ptr <= wr_ptr + OAW'(1);
    end
  end

  pool_max4 #(.DW(DW)) u_max4 (
    .PCLK         (PCLK),
    .PRESET       (PRESET),
    .phase        (dv_phase),
    .data_valid   (dv_q),
    .data         (in_rd_data),
    .result       (res_dat),
    .result_valid (res_vld)
  );

  assign out_wr_en   = res_vld;
  assign out_wr_addr = wr_ptr;
  assign out_wr_data = res_dat;

endmodule

// File: tb/tb_pool_ctrl.sv
// Directed bench for pool_ctrl: reset, 4x4 map, odd dims with address wrap, signed max/ReLU,
// degenerate jobs, start-edge handling and mid-job reset. Cycles are counted from start detection.
module tb_pool_ctrl;
  localparam int DW  = 8;
  localparam int IAW = 25;
  localparam int OAW = 16;

  logic           PCLK = 1'b0;
  logic           PRESET, pool_start;
  logic [7:0]     width, height;
  logic [8:0]     length;
  logic [OAW-1:0] out_base;
  logic           pool_done;
  logic [31:0]    clk_counter;
  logic           in_rd_en;
  logic [IAW-1:0] in_rd_addr;
  logic [DW-1:0]  in_rd_data;
  logic           out_wr_en;
  logic [OAW-1:0] out_wr_addr;
  logic [DW-1:0]  out_wr_data;

  int n_chk = 0, n_pass = 0;
  int edge_n = 0, t0 = 0;
  int rd_addr_q[$], rd_cyc_q[$], wr_addr_q[$], wr_dat_q[$], wr_cyc_q[$];
  bit done_seen = 1'b0;
  int done_cyc = 0;
  logic [31:0] done_cnt = '0;
  logic [7:0] mem [0:255];

  pool_ctrl #(.DW(DW), .IAW(IAW), .OAW(OAW)) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .pool_start  (pool_start),
    .width       (width),
    .height      (height),
    .length      (length),
    .out_base    (out_base),
    .pool_done   (pool_done),
    .clk_counter (clk_counter),
    .in_rd_en    (in_rd_en),
    .in_rd_addr  (in_rd_addr),
    .in_rd_data  (in_rd_data),
    .out_wr_en   (out_wr_en),
    .out_wr_addr (out_wr_addr),
    .out_wr_data (out_wr_data)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) edge_n <= edge_n + 1;
  always @(posedge PCLK) in_rd_data <= in_rd_en ? mem[in_rd_addr[7:0]] : 8'h00;

  always @(negedge PCLK) begin
    if (in_rd_en) begin
      rd_addr_q.push_back(int'(in_rd_addr));
      rd_cyc_q.push_back(edge_n - t0);
    end
    if (out_wr_en) begin
      wr_addr_q.push_back(int'(out_wr_addr));
      wr_dat_q.push_back(int'(out_wr_data));
      wr_cyc_q.push_back(edge_n - t0);
    end
    if (pool_done && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = edge_n - t0;
      done_cnt  = clk_counter;
    end
  end

  task automatic start_job(input logic [7:0] w, input logic [7:0] h, input logic [8:0] c,
                           input logic [OAW-1:0] base);
    @(negedge PCLK); #1;
    rd_addr_q.delete(); rd_cyc_q.delete();
    wr_addr_q.delete(); wr_dat_q.delete(); wr_cyc_q.delete();
    done_seen = 1'b0;
    width = w; height = h; length = c; out_base = base;
    pool_start = 1'b1;
    t0 = edge_n + 1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge PCLK);
      if (done_seen) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    PRESET = 1'b1; pool_start = 1'b0;
    width = 8'd0; height = 8'd0; length = 9'd0; out_base = '0;
    repeat (3) @(negedge PCLK);
    n_chk++; if ({pool_done, clk_counter} !== 33'd0) $display("FAIL reset_done_cnt: got %0d/%0d want 0/0", pool_done, clk_counter); else n_pass++;
    n_chk++; if ({in_rd_en, in_rd_addr} !== '0) $display("FAIL reset_rd: got en=%0d addr=%0d want 0", in_rd_en, in_rd_addr); else n_pass++;
    n_chk++; if ({out_wr_en, out_wr_addr, out_wr_data} !== '0) $display("FAIL reset_wr: got en=%0d addr=%0d dat=%0d want 0", out_wr_en, out_wr_addr, out_wr_data); else n_pass++;
    PRESET = 1'b0;
    repeat (2) @(negedge PCLK);
  endtask

  task automatic test_4x4;
    int exp_rd [16];
    int exp_wr [4];
    bit ok;
    exp_rd = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
    exp_wr = '{5, 7, 13, 15};
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    start_job(8'd4, 8'd4, 9'd1, 16'd0);
    wait_done(200, ok);
    n_chk++; if (!ok) $display("FAIL 4x4_timeout: pool_done never rose"); else n_pass++;
    n_chk++; if (done_cyc !== 19 || done_cnt !== 32'd19) $display("FAIL 4x4_done: got cyc=%0d cnt=%0d want 19/19", done_cyc, done_cnt); else n_pass++;
    n_chk++; if (rd_addr_q.size() !== 16) $display("FAIL 4x4_rd_count: got %0d want 16", rd_addr_q.size()); else n_pass++;
    for (int i = 0; i < rd_addr_q.size() && i < 16; i++) begin
      n_chk++; if (rd_addr_q[i] !== exp_rd[i] || rd_cyc_q[i] !== i + 1) $display("FAIL 4x4_rd%0d: got addr=%0d cyc=%0d want %0d/%0d", i, rd_addr_q[i], rd_cyc_q[i], exp_rd[i], i + 1); else n_pass++;
    end
    n_chk++; if (wr_dat_q.size() !== 4) $display("FAIL 4x4_wr_count: got %0d want 4", wr_dat_q.size()); else n_pass++;
    for (int i = 0; i < wr_dat_q.size() && i < 4; i++) begin
      n_chk++; if (wr_dat_q[i] !== exp_wr[i] || wr_addr_q[i] !== i || wr_cyc_q[i] !== 4 * i + 6) $display("FAIL 4x4_wr%0d: got dat=%0d addr=%0d cyc=%0d want %0d/%0d/%0d", i, wr_dat_q[i], wr_addr_q[i], wr_cyc_q[i], exp_wr[i], i, 4 * i + 6); else n_pass++;
    end
    repeat (3) @(negedge PCLK);
    n_chk++; if (clk_counter !== 32'd19) $display("FAIL 4x4_cnt_frozen: got %0d want 19", clk_counter); else n_pass++;
    pool_start = 1'b0;
    repeat (3) @(negedge PCLK);
  endtask

  task automatic test_odd_dims;
    int exp_rd [16];
    int exp_wr [4];
    int exp_wa [4];
    bit ok;
    exp_rd = '{0, 1, 5, 6, 2, 3, 7, 8, 15, 16, 20, 21, 17, 18, 22, 23};
    exp_wr = '{57, 47, 43, 53};
    exp_wa = '{16'hFFFE, 16'hFFFF, 0, 1};
    for (int i = 0; i < 256; i++) mem[i] = 8'((i * 37) % 64);
    start_job(8'd5, 8'd3, 9'd2, 16'hFFFE);
    wait_done(200, ok);
    n_chk++; if (!ok || done_cyc !== 19 || done_cnt !== 32'd19) $display("FAIL odd_done: got ok=%0d cyc=%0d cnt=%0d want 1/19/19", ok, done_cyc, done_cnt); else n_pass++;
    n_chk++; if (rd_addr_q.size() !== 16) $display("FAIL odd_rd_count: got %0d want 16", rd_addr_q.size()); else n_pass++;
    for (int i = 0; i < rd_addr_q.size() && i < 16; i++) begin
      n_chk++; if (rd_addr_q[i] !== exp_rd[i]) $display("FAIL odd_rd%0d: got %0d want %0d", i, rd_addr_q[i], exp_rd[i]); else n_pass++;
    end
    n_chk++; if (wr_dat_q.size() !== 4) $display("FAIL odd_wr_count: got %0d want 4", wr_dat_q.size()); else n_pass++;
    for (int i = 0; i < wr_dat_q.size() && i < 4; i++) begin
      n_chk++; if (wr_dat_q[i] !== exp_wr[i] || wr_addr_q[i] !== exp_wa[i]) $display("FAIL odd_wr%0d: got dat=%0d addr=%0d want %0d/%0d", i, wr_dat_q[i], wr_addr_q[i], exp_wr[i], exp_wa[i]); else n_pass++;
    end
    pool_start = 1'b0;
    repeat (3) @(negedge PCLK);
  endtask

  task automatic test_signed_max;
    bit ok;
    int exp0;
    mem[0] = 8'h80; mem[1] = 8'hFD; mem[4] = 8'hF9; mem[5] = 8'h9C;
    mem[2] = 8'h7E; mem[3] = 8'hFF; mem[6] = 8'h80; mem[7] = 8'h01;
`ifdef POOL_RELU_EN
    exp0 = 0;
`else
    exp0 = 253;
`endif
    start_job(8'd4, 8'd2, 9'd1, 16'd10);
    wait_done(100, ok);
    n_chk++; if (!ok || done_cyc !== 11 || done_cnt !== 32'd11) $display("FAIL neg_done: got ok=%0d cyc=%0d cnt=%0d want 1/11/11", ok, done_cyc, done_cnt); else n_pass++;
    n_chk++; if (wr_dat_q.size() !== 2) $display("FAIL neg_wr_count: got %0d want 2", wr_dat_q.size()); else n_pass++;
    if (wr_dat_q.size() == 2) begin
      n_chk++; if (wr_dat_q[0] !== exp0 || wr_addr_q[0] !== 10 || wr_cyc_q[0] !== 6) $display("FAIL neg_win0: got dat=%0d addr=%0d cyc=%0d want %0d/10/6", wr_dat_q[0], wr_addr_q[0], wr_cyc_q[0], exp0); else n_pass++;
      n_chk++; if (wr_dat_q[1] !== 126 || wr_addr_q[1] !== 11 || wr_cyc_q[1] !== 10) $display("FAIL neg_win1: got dat=%0d addr=%0d cyc=%0d want 126/11/10", wr_dat_q[1], wr_addr_q[1], wr_cyc_q[1]); else n_pass++;
    end
    pool_start = 1'b0;
    repeat (3) @(negedge PCLK);
  endtask

  task automatic test_degenerate;
    logic [7:0] ws [2];
    logic [8:0] cs [2];
    bit ok;
    ws = '{8'd1, 8'd4};
    cs = '{9'd1, 9'd0};
    for (int k = 0; k < 2; k++) begin
      start_job(ws[k], 8'd4, cs[k], 16'd0);
      wait_done(20, ok);
      n_chk++; if (!ok || done_cyc !== 2 || done_cnt !== 32'd1) $display("FAIL degen%0d_done: got ok=%0d cyc=%0d cnt=%0d want 1/2/1", k, ok, done_cyc, done_cnt); else n_pass++;
      repeat (4) @(negedge PCLK);
      n_chk++; if (rd_addr_q.size() !== 0 || wr_dat_q.size() !== 0) $display("FAIL degen%0d_traffic: got rd=%0d wr=%0d want 0/0", k, rd_addr_q.size(), wr_dat_q.size()); else n_pass++;
      pool_start = 1'b0;
      repeat (3) @(negedge PCLK);
    end
  endtask

  task automatic test_start_handling;
    bit ok;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    start_job(8'd4, 8'd4, 9'd1, 16'd0);
    repeat (8) @(negedge PCLK);
    pool_start = 1'b0;
    @(negedge PCLK);
    pool_start = 1'b1;
    wait_done(200, ok);
    n_chk++; if (!ok || done_cyc !== 19 || done_cnt !== 32'd19) $display("FAIL pulse_done: got ok=%0d cyc=%0d cnt=%0d want 1/19/19", ok, done_cyc, done_cnt); else n_pass++;
    n_chk++; if (wr_dat_q.size() !== 4 || rd_addr_q.size() !== 16) $display("FAIL pulse_traffic: got wr=%0d rd=%0d want 4/16", wr_dat_q.size(), rd_addr_q.size()); else n_pass++;
    repeat (10) @(negedge PCLK);
    n_chk++; if (pool_done !== 1'b1 || clk_counter !== 32'd19) $display("FAIL hold_done: got done=%0d cnt=%0d want 1/19", pool_done, clk_counter); else n_pass++;
    n_chk++; if (rd_addr_q.size() !== 16) $display("FAIL hold_relaunch: got reads=%0d want 16", rd_addr_q.size()); else n_pass++;
    pool_start = 1'b0;
    repeat (2) @(negedge PCLK);
    n_chk++; if (pool_done !== 1'b0 || in_rd_en !== 1'b0) $display("FAIL drop_idle: got done=%0d rd_en=%0d want 0/0", pool_done, in_rd_en); else n_pass++;
    start_job(8'd4, 8'd4, 9'd1, 16'd0);
    wait_done(200, ok);
    n_chk++; if (!ok || done_cyc !== 19 || wr_dat_q.size() !== 4) $display("FAIL rerise_job: got ok=%0d cyc=%0d wr=%0d want 1/19/4", ok, done_cyc, wr_dat_q.size()); else n_pass++;
    pool_start = 1'b0;
    repeat (3) @(negedge PCLK);
  endtask

  task automatic test_reset_midjob;
    int exp_wr [4];
    bit ok;
    exp_wr = '{5, 7, 13, 15};
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    start_job(8'd4, 8'd4, 9'd1, 16'd0);
    repeat (10) @(negedge PCLK);
    #1;
    PRESET = 1'b1;
    pool_start = 1'b0;
    #1;
    n_chk++; if ({pool_done, clk_counter, in_rd_en, in_rd_addr} !== '0) $display("FAIL mid_rst_rd: got done=%0d cnt=%0d en=%0d addr=%0d want 0", pool_done, clk_counter, in_rd_en, in_rd_addr); else n_pass++;
    n_chk++; if ({out_wr_en, out_wr_addr, out_wr_data} !== '0) $display("FAIL mid_rst_wr: got en=%0d addr=%0d dat=%0d want 0", out_wr_en, out_wr_addr, out_wr_data); else n_pass++;
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    repeat (30) @(negedge PCLK);
    n_chk++; if (rd_addr_q.size() !== 9 || wr_dat_q.size() !== 1 || done_seen) $display("FAIL mid_rst_abandon: got rd=%0d wr=%0d done=%0d want 9/1/0", rd_addr_q.size(), wr_dat_q.size(), done_seen); else n_pass++;
    start_job(8'd4, 8'd4, 9'd1, 16'd8);
    wait_done(200, ok);
    n_chk++; if (!ok || done_cyc !== 19 || done_cnt !== 32'd19) $display("FAIL after_rst_done: got ok=%0d cyc=%0d cnt=%0d want 1/19/19", ok, done_cyc, done_cnt); else n_pass++;
    n_chk++; if (wr_dat_q.size() !== 4) $display("FAIL after_rst_wr_count: got %0d want 4", wr_dat_q.size()); else n_pass++;
    for (int i = 0; i < wr_dat_q.size() && i < 4; i++) begin
      n_chk++; if (wr_dat_q[i] !== exp_wr[i] || wr_addr_q[i] !== 8 + i) $display("FAIL after_rst_wr%0d: got dat=%0d addr=%0d want %0d/%0d", i, wr_dat_q[i], wr_addr_q[i], exp_wr[i], 8 + i); else n_pass++;
    end
    pool_start = 1'b0;
    repeat (3) @(negedge PCLK);
  endtask

  initial begin
    test_reset();
    test_4x4();
    test_odd_dims();
    test_signed_max();
    test_degenerate();
    test_start_handling();
    test_reset_midjob();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pool_ctrl.md
# pool_ctrl

Sequencer for the 2x2/stride-2 max-pooling engine. It sits behind the pooling APB register block and consumes its `pool_start`, `width`, `length` and `height` configuration. It walks the input feature map in an on-chip buffer, reduces each 2x2 window to its signed maximum, and writes the results to the output buffer. It returns `pool_done` and `clk_counter` to the register block for software readback.

## Interface

**Parameters**
- `DW`, 8: element width; signed two's complement.
- `IAW`, 25: input buffer address width; holds the worst case 511x255x255.
- `OAW`, 16: output buffer address width.

**Ports**
- `PCLK` in 1: clock.
- `PRESET` in 1: asynchronous, active-high reset.
- `pool_start` in 1: level from the register block; a rising edge launches a job.
- `width` in 8: input map width W.
- `height` in 8: input map height H.
- `length` in 9: channel count C.
- `out_base` in OAW: first output write address.
- `pool_done` out 1: job complete.
- `clk_counter` out 32: cycles consumed by the last or current job.
- `in_rd_en` out 1: input buffer read strobe.
- `in_rd_addr` out IAW: input buffer read address.
- `in_rd_data` in DW: input read data, valid exactly 1 cycle after `in_rd_en`.
- `out_wr_en` out 1: output buffer write strobe.
- `out_wr_addr` out OAW: output write address.
- `out_wr_data` out DW: pooled value.

## Operation

**Memory layout**
- Input is channel-major: element (c,y,x) is at address c·W·H + y·W + x.
- Output dimensions: Wo=floor(W/2), Ho=floor(H/2). An odd trailing column or row is ignored.
- Output is packed channel-major starting at `out_base`, N = Wo·Ho·C words.

**FSM states**
- IDLE: waits for `pool_start` high while its registered copy is low.
- SETUP: one cycle. Latches W, H, C and `out_base`; computes W·H with the only multiplier; clears `clk_counter`. If Wo, Ho or C is 0, it goes to DONE; otherwise it goes to READ.
- READ: issues one read every cycle, in window order top-left, top-right, bottom-left, bottom-right (base, base+1, base+W, base+W+1). Windows advance x, then y, then c.
  - Pointers: `row_base` and `chan_base` are updated by addition only.
  - Next window: base += 2.
  - Next output row: row_base += 2W.
  - Next channel: chan_base += W·H, and row_base = chan_base.
- DRAIN: entered after the final read. Waits for the last write, then goes to DONE.
- DONE: holds `pool_done`=1. Returns to IDLE when `pool_start` is low.

**Datapath behaviour**
- Max accumulator: loads on the first element of a window and takes a signed max on the next three.
- `out_wr_en` pulses one cycle after the fourth element arrives. `out_wr_addr` increments by 1 per write, with no saturation (mod 2^OAW).
- `clk_counter` increments every cycle in SETUP, READ and DRAIN. It freezes on entering DONE and holds until the next SETUP.
- A rising edge of `pool_start` outside IDLE is ignored, with no restart.
- `pool_start` still high on leaving DONE does not relaunch; a fresh rising edge is required.

**Reset**
- All outputs and state clear to 0 and the FSM goes to IDLE.
- Reset mid-job abandons the job with no further reads or writes; no partial `pool_done`.

## Timing

- Cycle 0: the edge where the start rise is detected; the FSM enters SETUP.
- Reads run from cycle 1 to cycle 4N, one per cycle, with no bubbles between windows, rows or channels.
- Write k (0-based) occurs at cycle 4k+6. The last write is at 4N+2.
- `pool_done` rises at cycle 4N+3 with `clk_counter` = 4N+3.
- Degenerate job: `pool_done` at cycle 2 with `clk_counter` = 1.
- Sustained throughput: one output per 4 cycles.

## Configuration

- `POOL_RELU_EN` defined: a negative maximum is written as 0, i.e. ReLU is fused.
- `POOL_RELU_EN` undefined: the raw signed maximum is written.
- Timing is identical in both builds.

## Structure

- Package `pool_pkg`: FSM state enum (IDLE, SETUP, READ, DRAIN, DONE), default `DW`/`IAW`/`OAW`, 2-bit window-phase encoding.
- Sub-module `pool_max4`: running signed max over 4 elements with the optional ReLU. Inputs: phase, data_valid. Outputs: result, result_valid.
- The FSM, address pointers and counters live in `pool_ctrl`.

## Test plan

1. **4x4x1 map.** W=4, H=4, C=1, values 0..15, `out_base`=0.
   - Writes 5, 7, 13, 15 to addresses 0..3 at cycles 6, 10, 14, 18.
   - `pool_done` at cycle 19 with `clk_counter`=19.
2. **Odd dimensions, two channels.** W=5, H=3, C=2.
   - Wo=2, Ho=1, N=4.
   - Channel-1 reads start at address 15.
   - The final read address is 23 (channel 1, bottom-right of window x=1).
3. **All-negative window.** Window {-128, -3, -7, -100}.
   - Writes -3 (8'hFD) without `POOL_RELU_EN`.
   - Writes 0 with `POOL_RELU_EN`.
4. **Degenerate job.** W=1 (or C=0).
   - No reads, no writes.
   - `pool_done` at cycle 2 with `clk_counter`=1.
5. **Start handling.** Pulse `pool_start` again mid-job; later hold it high through DONE.
   - The mid-job pulse is ignored and the job completes normally.
   - Held high: no relaunch until it drops and rises again.
6. **Reset mid-job.** Assert `PRESET` at cycle 9 of a 4x4x1 job.
   - All outputs go to 0 immediately.
   - After release, a new start runs the full job correctly.
